// File: rtl/ipsxb_fft_peak_search_if.sv
// FFT output stream as seen by the peak search: packed re/im lanes, frame end,
// and the bin-index / block-exponent sideband. No back-pressure on this stream.
interface ipsxb_fft_peak_search_if #(
  parameter int DATAOUT_WIDTH = 16,
  parameter int USER_WIDTH    = 24
);
  logic                       tvalid;
  logic [2*DATAOUT_WIDTH-1:0] tdata;
  logic                       tlast;
  logic [USER_WIDTH-1:0]      tuser;

  modport master (output tvalid, tdata, tlast, tuser);
  modport slave  (input  tvalid, tdata, tlast, tuser);
endinterface

// File: rtl/ipsxb_fft_peak_search.sv
// Per-frame peak search on FFT output: power per bin, windowed maximum,
// frame-integrity checking, and a one-cycle result strobe per frame.
module ipsxb_fft_peak_search #(
  parameter int LOGS_FFT_LEN  = 13,
  parameter int DATA_WIDTH    = 11,
  parameter int DATAOUT_WIDTH = 16,
  parameter int USER_WIDTH    = 24,
  parameter int MIN_BIN       = 1,
  parameter int MAX_BIN       = 4095
) (
  input  logic                    i_aclk,
  input  logic                    i_areset,
  input  logic                    i_aclken,
  ipsxb_fft_peak_search_if.slave  s_axis,
  output logic                    o_peak_valid,
  output logic [LOGS_FFT_LEN-1:0] o_peak_index,
  output logic [2*DATA_WIDTH-1:0] o_peak_power,
  output logic [7:0]              o_blk_exp,
  output logic                    o_frame_err,
  output logic [15:0]             o_frame_cnt
);
  localparam int SQ_W  = 2*DATA_WIDTH-1;
  localparam int PWR_W = 2*DATA_WIDTH;
  localparam logic [LOGS_FFT_LEN-1:0] LAST_BEAT = '1;
  localparam logic [LOGS_FFT_LEN-1:0] WIN_LO    = LOGS_FFT_LEN'(MIN_BIN);
  localparam logic [LOGS_FFT_LEN-1:0] WIN_HI    = LOGS_FFT_LEN'(MAX_BIN);

  // Square of a signed component; the top bit of the full product is always 0.
  function automatic logic [SQ_W-1:0] f_square(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [PWR_W-1:0] xe;
    logic signed [PWR_W-1:0] prod;
    xe   = PWR_W'(x);
    prod = xe * xe;
    return prod[SQ_W-1:0];
  endfunction

  function automatic logic [PWR_W-1:0] f_power(input logic [SQ_W-1:0] a,
                                               input logic [SQ_W-1:0] b);
    return PWR_W'(a) + PWR_W'(b);
  endfunction

  logic [LOGS_FFT_LEN-1:0] r_beat_cnt;
  logic                    r_frm_err;

  logic                    r_vld_p0, r_vld_p1, r_vld_p2;
  logic                    r_last_p0, r_last_p1, r_last_p2;
  logic                    r_err_p0, r_err_p1, r_err_p2;

  logic signed [DATA_WIDTH-1:0] r_re_p0, r_im_p0;
  logic [SQ_W-1:0]              r_sqre_p1, r_sqim_p1;
  logic [PWR_W-1:0]             r_pwr_p2;
  logic [LOGS_FFT_LEN-1:0]      r_idx_p0, r_idx_p1, r_idx_p2;
  logic [7:0]                   r_exp_p0, r_exp_p1, r_exp_p2;

  logic                    r_have;
  logic [PWR_W-1:0]        r_run_max;
  logic [LOGS_FFT_LEN-1:0] r_run_idx;

  logic [LOGS_FFT_LEN-1:0] w_in_idx;
  logic                    w_beat_err;
  logic                    w_in_win;
  logic                    w_take;
  logic                    w_eof;
  logic [PWR_W-1:0]        w_max_nxt;
  logic [LOGS_FFT_LEN-1:0] w_idx_nxt;

  assign w_in_idx   = s_axis.tuser[LOGS_FFT_LEN-1:0];
  // Out-of-order bin, early tlast, or a full frame with no tlast.
  assign w_beat_err = (w_in_idx != r_beat_cnt) ||
                      (s_axis.tlast ? (r_beat_cnt != LAST_BEAT) : (r_beat_cnt == LAST_BEAT));

  assign w_in_win  = r_vld_p2 && (r_idx_p2 >= WIN_LO) && (r_idx_p2 <= WIN_HI);
  assign w_take    = w_in_win && (!r_have || (r_pwr_p2 > r_run_max));
  assign w_max_nxt = w_take ? r_pwr_p2 : r_run_max;
  assign w_idx_nxt = w_take ? r_idx_p2 : r_run_idx;
  assign w_eof     = r_vld_p2 && r_last_p2;

  always_ff @(posedge i_aclk) begin
    if (i_areset) begin
      r_beat_cnt   <= '0;
      r_frm_err    <= 1'b0;
      r_vld_p0     <= 1'b0;
      r_vld_p1     <= 1'b0;
      r_vld_p2     <= 1'b0;
      r_last_p0    <= 1'b0;
      r_last_p1    <= 1'b0;
      r_last_p2    <= 1'b0;
      r_err_p0     <= 1'b0;
      r_err_p1     <= 1'b0;
      r_err_p2     <= 1'b0;
      r_have       <= 1'b0;
      r_run_max    <= '0;
      r_run_idx    <= '0;
      o_peak_valid <= 1'b0;
      o_peak_index <= '0;
      o_peak_power <= '0;
      o_blk_exp    <= '0;
      o_frame_err  <= 1'b0;
      o_frame_cnt  <= '0;
    end else if (i_aclken) begin
      // S1: frame tracking on the input side
      r_vld_p0  <= s_axis.tvalid;
      r_last_p0 <= s_axis.tvalid & s_axis.tlast;
      r_err_p0  <= r_frm_err | w_beat_err;
      if (s_axis.tvalid) begin
        r_beat_cnt <= s_axis.tlast ? '0 : r_beat_cnt + LOGS_FFT_LEN'(1);
        r_frm_err  <= ~s_axis.tlast & (r_frm_err | w_beat_err);
      end
      // S2
      r_vld_p1  <= r_vld_p0;
      r_last_p1 <= r_last_p0;
      r_err_p1  <= r_err_p0;
      // S3
      r_vld_p2  <= r_vld_p1;
      r_last_p2 <= r_last_p1;
      r_err_p2  <= r_err_p1;
      // Search and result: the frame end publishes the max including its own beat.
      o_peak_valid <= w_eof;
      if (w_eof) begin
        o_peak_index <= w_idx_nxt;
        o_peak_power <= w_max_nxt;
        o_blk_exp    <= r_exp_p2;
        o_frame_err  <= r_err_p2;
        o_frame_cnt  <= o_frame_cnt + 16'd1;
        r_have       <= 1'b0;
        r_run_max    <= '0;
        r_run_idx    <= '0;
      end else if (w_take) begin
        r_have       <= 1'b1;
        r_run_max    <= w_max_nxt;
        r_run_idx    <= w_idx_nxt;
      end
    end
  end

  always_ff @(posedge i_aclk) begin
    if (i_aclken) begin
      // S1
      r_re_p0   <= s_axis.tdata[DATA_WIDTH-1:0];
      r_im_p0   <= s_axis.tdata[DATAOUT_WIDTH +: DATA_WIDTH];
      r_idx_p0  <= w_in_idx;
      r_exp_p0  <= s_axis.tuser[USER_WIDTH-1 -: 8];
      // S2
      r_sqre_p1 <= f_square(r_re_p0);
      r_sqim_p1 <= f_square(r_im_p0);
      r_idx_p1  <= r_idx_p0;
      r_exp_p1  <= r_exp_p0;
      // S3
      r_pwr_p2  <= f_power(r_sqre_p1, r_sqim_p1);
      r_idx_p2  <= r_idx_p1;
      r_exp_p2  <= r_exp_p1;
    end
  end
endmodule

// File: tb/tb_ipsxb_fft_peak_search.sv
// Randomized bench for ipsxb_fft_peak_search: a frame-level reference model,
// a per-cycle output compare process, and pinned results for the planned scenarios.
module tb_ipsxb_fft_peak_search;
  localparam int LOGN = 13;
  localparam int N    = 1 << LOGN;
  localparam int DW   = 11;
  localparam int MINB = 1;
  localparam int MAXB = 4095;

  logic            clk = 1'b0;
  logic            areset;
  logic            aclken;
  logic            o_peak_valid;
  logic [LOGN-1:0] o_peak_index;
  logic [2*DW-1:0] o_peak_power;
  logic [7:0]      o_blk_exp;
  logic            o_frame_err;
  logic [15:0]     o_frame_cnt;

  ipsxb_fft_peak_search_if #(.DATAOUT_WIDTH(16), .USER_WIDTH(24)) s_if ();

  ipsxb_fft_peak_search #(
    .LOGS_FFT_LEN(LOGN), .DATA_WIDTH(DW), .DATAOUT_WIDTH(16),
    .USER_WIDTH(24), .MIN_BIN(MINB), .MAX_BIN(MAXB)
  ) dut (
    .i_aclk       (clk),
    .i_areset     (areset),
    .i_aclken     (aclken),
    .s_axis       (s_if),
    .o_peak_valid (o_peak_valid),
    .o_peak_index (o_peak_index),
    .o_peak_power (o_peak_power),
    .o_blk_exp    (o_blk_exp),
    .o_frame_err  (o_frame_err),
    .o_frame_cnt  (o_frame_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { int due; int idx; int pwr; int exp; int err; int cnt; } res_t;

  res_t exp_q[$];
  res_t rlog[$];
  res_t cur;
  int   n_pass = 0;
  int   n_tot  = 0;
  int   en_edges = 0;
  bit   chk_on = 1'b0;
  int   rec_edge = -1;

  int   m_cnt, m_err, m_fcnt;
  int   fb_idx[$];
  int   fb_pwr[$];
  int   f_re[N];
  int   f_im[N];
  int   f_uidx[N];

  always @(posedge clk) if (aclken) en_edges <= en_edges + 1;

  task automatic chk(input string name, input longint act, input longint req);
    n_tot++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
  endtask

  task automatic model_reset();
    m_cnt = 0; m_err = 0; m_fcnt = 0;
    fb_idx.delete(); fb_pwr.delete(); exp_q.delete();
    cur = '{default: 0};
  endtask

  // Frame-level model: collect the frame, then scan it at tlast.
  task automatic model_beat(input int re, input int im, input int uidx, input bit last,
                            input int bexp, input int due);
    res_t r;
    int   best_i;
    int   best_p;
    bit   found;
    if ((uidx != m_cnt) || (last != (m_cnt == N-1))) m_err = 1;
    fb_idx.push_back(uidx);
    fb_pwr.push_back(re*re + im*im);
    m_cnt = (m_cnt + 1) % N;
    if (last) begin
      best_i = 0; best_p = 0; found = 1'b0;
      foreach (fb_idx[k])
        if (fb_idx[k] >= MINB && fb_idx[k] <= MAXB && (!found || fb_pwr[k] > best_p)) begin
          found = 1'b1; best_i = fb_idx[k]; best_p = fb_pwr[k];
        end
      m_fcnt = (m_fcnt + 1) % 65536;
      r = '{due: due, idx: best_i, pwr: best_p, exp: bexp, err: m_err, cnt: m_fcnt};
      exp_q.push_back(r);
      m_cnt = 0; m_err = 0;
      fb_idx.delete(); fb_pwr.delete();
    end
  endtask

  always @(negedge clk) begin : compare
    bit exp_v;
    if (chk_on) begin
      while (exp_q.size() > 0 && exp_q[0].due < en_edges) void'(exp_q.pop_front());
      exp_v = (exp_q.size() > 0 && exp_q[0].due == en_edges);
      if (exp_v) cur = exp_q[0];
      chk("peak_valid", o_peak_valid, exp_v);
      if (exp_v || (en_edges % 16 == 0)) begin
        chk("peak_index", o_peak_index, cur.idx);
        chk("peak_power", o_peak_power, cur.pwr);
        chk("blk_exp",    o_blk_exp,    cur.exp);
        chk("frame_err",  o_frame_err,  cur.err);
        chk("frame_cnt",  o_frame_cnt,  cur.cnt);
      end
      if (o_peak_valid && rec_edge != en_edges) begin
        rec_edge = en_edges;
        rlog.push_back('{due: en_edges, idx: int'(o_peak_index), pwr: int'(o_peak_power),
                         exp: int'(o_blk_exp), err: int'(o_frame_err), cnt: int'(o_frame_cnt)});
      end
    end
  end

  task automatic fill_zero();
    for (int i = 0; i < N; i++) begin f_re[i] = 0; f_im[i] = 0; f_uidx[i] = i; end
  endtask

  task automatic fill_noise(input int amp);
    for (int i = 0; i < N; i++) begin
      f_re[i]   = int'($urandom_range(2*amp)) - amp;
      f_im[i]   = int'($urandom_range(2*amp)) - amp;
      f_uidx[i] = i;
    end
  endtask

  task automatic send_frame(input int len, input bit with_last, input bit slow,
                            input int gap_pct, input int bexp);
    int          i;
    int          ph;
    bit          en;
    bit          gap;
    bit          lst;
    logic [31:0] tr;
    logic [31:0] ti;
    logic [7:0]  ex;
    i = 0; ph = 0;
    while (i < len) begin
      en  = slow ? (ph % 3 == 0) : 1'b1;
      gap = ($urandom_range(99) < gap_pct);
      ph++;
      lst = with_last && (i == len-1);
      tr  = f_re[i];
      ti  = f_im[i];
      ex  = lst ? bexp[7:0] : 8'($urandom);
      aclken       = en;
      s_if.tvalid  = !gap;
      s_if.tdata   = {ti[15:0], tr[15:0]};
      s_if.tlast   = lst;
      s_if.tuser   = {ex, 3'b000, f_uidx[i][LOGN-1:0]};
      if (en && !gap) begin
        model_beat(f_re[i], f_im[i], f_uidx[i] % N, lst, bexp, en_edges + 4);
        i++;
      end
      @(posedge clk); #1;
    end
    s_if.tvalid = 1'b0; s_if.tlast = 1'b0; aclken = 1'b1;
  endtask

  task automatic drain();
    int k;
    k = 0;
    aclken = 1'b1; s_if.tvalid = 1'b0;
    while (exp_q.size() > 0 && k < 40) begin @(posedge clk); #1; k++; end
    chk("drain_pending", exp_q.size(), 0);
  endtask

  task automatic do_reset();
    aclken = 1'b1; s_if.tvalid = 1'b0; s_if.tlast = 1'b0; areset = 1'b1;
    @(posedge clk); #1;
    areset = 1'b0;
    model_reset();
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_valid"}, o_peak_valid, 0);
    chk({tag, "_index"}, o_peak_index, 0);
    chk({tag, "_power"}, o_peak_power, 0);
    chk({tag, "_exp"},   o_blk_exp,    0);
    chk({tag, "_err"},   o_frame_err,  0);
    chk({tag, "_cnt"},   o_frame_cnt,  0);
  endtask

  initial begin : watchdog
    #5000000;
    $display("FAIL watchdog: bench did not finish, %0d/%0d so far", n_pass, n_tot);
    $fatal(1, "timeout");
  end

  initial begin : main
    int k;
    int n0;
    int pk;
    int last_i;
    areset = 1'b1; aclken = 1'b1;
    s_if.tvalid = 1'b0; s_if.tdata = '0; s_if.tlast = 1'b0; s_if.tuser = '0;
    repeat (3) @(posedge clk);
    #1 areset = 1'b0;
    model_reset();
    chk_on = 1'b1;
    @(negedge clk);
    chk_outputs_zero("reset");
    @(posedge clk); #1;

    // Tone: single bin at 100, measure strobe latency from the tlast edge
    fill_zero(); f_re[100] = 300; f_im[100] = -400;
    send_frame(N, 1'b1, 1'b0, 0, 'h5A);
    k = 0;
    while (!o_peak_valid && k < 20) begin @(posedge clk); #1; k++; end
    chk("tone_latency", k, 3);
    drain();
    last_i = rlog.size() - 1;
    chk("tone_index", rlog[last_i].idx, 100);
    chk("tone_power", rlog[last_i].pwr, 250000);
    chk("tone_exp",   rlog[last_i].exp, 'h5A);
    chk("tone_err",   rlog[last_i].err, 0);
    chk("tone_cnt",   rlog[last_i].cnt, 1);

    // DC excluded, tie keeps lower bin, bin above the window ignored
    fill_zero();
    f_re[0] = 1023; f_re[5] = -1024; f_re[9] = -1024;
    f_re[5000] = -1024; f_im[5000] = -1024;
    send_frame(N, 1'b1, 1'b0, 10, 'h07);
    drain();
    last_i = rlog.size() - 1;
    chk("tie_index", rlog[last_i].idx, 5);
    chk("tie_power", rlog[last_i].pwr, 1048576);
    chk("tie_cnt",   rlog[last_i].cnt, 2);

    // Early tlast, followed back-to-back by a well-formed frame
    n0 = rlog.size();
    fill_noise(200);
    send_frame(8001, 1'b1, 1'b0, 0, 'h21);
    fill_noise(200);
    pk = int'($urandom_range(MAXB, MINB));
    f_re[pk] = 1000; f_im[pk] = -1000;
    send_frame(N, 1'b1, 1'b0, 0, 'h22);
    drain();
    chk("b2b_results", rlog.size() - n0, 2);
    if (rlog.size() - n0 == 2) begin
      chk("short_err",  rlog[n0].err, 1);
      chk("good_err",   rlog[n0+1].err, 0);
      chk("good_index", rlog[n0+1].idx, pk);
      chk("good_power", rlog[n0+1].pwr, 2000000);
      chk("good_cnt",   rlog[n0+1].cnt, 4);
    end

    // Bin index skips 11; peak placed on beat 500 which carries index 501
    fill_noise(200);
    for (int i = 11; i < N; i++) f_uidx[i] = (i + 1) % N;
    f_re[500] = 1000; f_im[500] = 1000;
    send_frame(N, 1'b1, 1'b0, 0, 'h33);
    drain();
    last_i = rlog.size() - 1;
    chk("skip_err",   rlog[last_i].err, 1);
    chk("skip_index", rlog[last_i].idx, 501);
    chk("skip_power", rlog[last_i].pwr, 2000000);

    // Tone again with the clock enable at 1-of-3 and random tvalid gaps
    n0 = rlog.size();
    fill_zero(); f_re[100] = 300; f_im[100] = -400;
    send_frame(N, 1'b1, 1'b1, 10, 'h3C);
    drain();
    chk("slow_results", rlog.size() - n0, 1);
    last_i = rlog.size() - 1;
    chk("slow_index", rlog[last_i].idx, 100);
    chk("slow_power", rlog[last_i].pwr, 250000);
    chk("slow_exp",   rlog[last_i].exp, 'h3C);
    chk("slow_err",   rlog[last_i].err, 0);
    chk("slow_cnt",   rlog[last_i].cnt, 6);

    // Reset in the middle of a frame, then one clean frame
    fill_zero(); f_re[100] = 300; f_im[100] = -400;
    send_frame(4000, 1'b0, 1'b0, 0, 'h00);
    do_reset();
    @(negedge clk);
    chk_outputs_zero("midreset");
    @(posedge clk); #1;
    n0 = rlog.size();
    send_frame(N, 1'b1, 1'b0, 5, 'h11);
    drain();
    chk("post_reset_results", rlog.size() - n0, 1);
    last_i = rlog.size() - 1;
    chk("post_reset_cnt",   rlog[last_i].cnt, 1);
    chk("post_reset_err",   rlog[last_i].err, 0);
    chk("post_reset_index", rlog[last_i].idx, 100);

    repeat (4) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule

// File: doc/ipsxb_fft_peak_search.md
Name: ipsxb_fft_peak_search

Overview:
- Sits directly downstream of the FFT core and consumes its output AXI4-Stream: packed re/im, tlast, and tuser carrying the bin index and block exponent.
- For every bin it computes the power re²+im², searches a programmable bin window for the maximum, and checks frame integrity.
- Once per frame it emits a one-cycle result strobe carrying peak index, peak power, block exponent and an error flag.
- Its results feed the on-board test/display logic in place of a full frame checker.

Parameters:
- LOGS_FFT_LEN, 13: log2 of the FFT length N.
- DATA_WIDTH, 11: significant bits per component; signed two's complement.
- DATAOUT_WIDTH, 16: byte-padded width of each component lane in tdata.
- USER_WIDTH, 24: tuser width.
- MIN_BIN, 1: lowest bin included in the search; 1 excludes DC.
- MAX_BIN, 4095: highest bin included in the search; default is N/2-1.

Ports:
- i_aclk  in  1  clock.
- i_areset  in  1  synchronous active-high reset; one clock, sync reset, active-high.
- i_aclken  in  1  clock enable; all state advances only when i_aclken=1.
- i_axi4s_data_tvalid  in  1  output bin valid from FFT; no tready, always accepted.
- i_axi4s_data_tdata  in  2*DATAOUT_WIDTH
  - re = bits [DATA_WIDTH-1:0]
  - im = bits [DATAOUT_WIDTH+DATA_WIDTH-1:DATAOUT_WIDTH]
- i_axi4s_data_tlast  in  1  last bin of frame.
- i_axi4s_data_tuser  in  USER_WIDTH
  - bin index = bits [LOGS_FFT_LEN-1:0]
  - blk_exp = bits [USER_WIDTH-1:USER_WIDTH-8]
- o_peak_valid  out  1  one-cycle result strobe.
- o_peak_index  out  LOGS_FFT_LEN  bin of maximum power.
- o_peak_power  out  2*DATA_WIDTH  maximum re²+im², unsigned.
- o_blk_exp  out  8  block exponent latched on the frame's tlast beat.
- o_frame_err  out  1  frame integrity error for this result.
- o_frame_cnt  out  16  completed frames since reset; wraps.

Behaviour:
- Reset:
  - All outputs reset to 0; pipeline valids cleared; beat counter = 0; running max = 0; running index = 0.
  - Reset mid-frame discards the partial frame. The next accepted beat starts a new frame.
- Enable:
  - When i_aclken=0, every register holds its value, including o_peak_valid.
  - Latencies below are counted in enabled cycles.
- Pipeline: 3 stages, each advancing on an enabled cycle.
  - S1: register sign-extended re and im, index, tlast, blk_exp, valid.
  - S2: compute re² and im², each 2*DATA_WIDTH-1 bits.
  - S3: power = re²+im² (2*DATA_WIDTH bits, cannot overflow), then search compare.
- Search, in S3 on a valid beat with MIN_BIN ≤ index ≤ MAX_BIN:
  - If power > running max (strict), update running max and running index. Ties keep the lower/earlier bin.
  - The first in-window bin of a frame always loads, even if its power is 0.
  - Bins outside the window are ignored. If no bin of the frame is in the window, index=0 and power=0 are reported.
- Frame checks, on the input side (S1 beat counter, 0..N-1). A frame error is set if any of:
  - tuser index ≠ beat counter (natural-order output is required);
  - tlast arrives with counter ≠ N-1;
  - counter reaches N-1 without tlast.
- Resync:
  - On tlast, the counter clears to 0.
  - On the missing-tlast error, the counter wraps to 0 and the frame continues to accumulate until tlast.
  - The error flag is sticky per frame and travels with the pipeline.
- Result emission:
  - On the enabled cycle after S3 processes the tlast beat, o_peak_valid=1 for one enabled cycle.
  - The same update loads o_peak_index, o_peak_power, o_blk_exp and o_frame_err, and increments o_frame_cnt.
  - Result outputs hold until the next result. The running max/index/error clear for the next frame in the same cycle.
  - Latency: tlast beat accepted at enabled cycle t gives o_peak_valid at t+4.
- Back-to-back frames: the first beat of frame k+1 may immediately follow tlast of frame k. The running state clear and the first-bin load must not conflict; the new beat wins.
- tvalid gaps: mid-frame gaps are allowed; counters and search state hold across them.
- blk_exp: sampled only from the tlast beat.

Test Plan:
- Tone test:
  - Stimulus: N=8192 frame, all bins re=im=0 except bin 100 re=300, im=-400.
  - Required: o_peak_valid 4 cycles after tlast, index=100, power=250000, err=0, frame_cnt=1.
- DC exclusion and tie:
  - Stimulus: bin 0 re=1023; bins 5 and 9 re=-1024; MIN_BIN=1.
  - Required: index=5, power=1048576.
- Frame error:
  - Stimulus: tlast asserted at beat 8000.
  - Required: result with err=1; next well-formed frame reports err=0 and its correct peak.
- Index mismatch:
  - Stimulus: tuser index jumps from 10 to 12 at beat 11.
  - Required: err=1; peak still computed over received bins.
- Enable and gaps:
  - Stimulus: i_aclken toggling 1-of-3 plus random tvalid gaps, same data as the tone test.
  - Required: identical result; o_peak_valid high for exactly one enabled cycle.
- Reset mid-frame:
  - Stimulus: i_areset pulsed at beat 4000, then one full frame.
  - Required: outputs 0 after reset; only one result, with frame_cnt=1 and err=0.
